// File: rtl/sram_cache_controller_if.sv
// MEM-stage request bus and SRAM-controller bus seen by the data cache.
// The cache takes the slave modport; the requester/SRAM side takes master.
interface sram_cache_controller_if;
    // MEM stage side
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    // SRAM controller side
    logic        sram_wr_en;
    logic        sram_rd_en;
    logic [31:0] sram_address;
    logic [31:0] sram_writeData;
    logic [63:0] sram_readData;
    logic        sram_ready;

    modport slave (
        input  wr_en, rd_en, address, writeData, sram_readData, sram_ready,
        output readData, ready, sram_wr_en, sram_rd_en, sram_address, sram_writeData
    );

    modport master (
        output wr_en, rd_en, address, writeData, sram_readData, sram_ready,
        input  readData, ready, sram_wr_en, sram_rd_en, sram_address, sram_writeData
    );
endinterface

// File: rtl/sram_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache in front
// of the SRAM controller. Read hits complete with zero stall; read misses fill
// a whole two-word line; every store is forwarded to SRAM.
module sram_cache_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int unsigned SET_BITS  = 6,
    parameter int unsigned TAG_BITS  = 10
) (
    input logic                    clk,
    input logic                    rst,
    sram_cache_controller_if.slave bus
);

    localparam int unsigned Sets   = 1 << SET_BITS;
    localparam int unsigned TagLsb = 3 + SET_BITS;

    typedef enum logic [1:0] {StIdle, StRdMiss, StWr} state_e;

    state_e              state_q;
    logic [Sets-1:0]     valid0_q, valid1_q;
    logic [Sets-1:0]     lru_q;  // value is the least recently used way
    logic [TAG_BITS-1:0] tag0_q  [Sets];
    logic [TAG_BITS-1:0] tag1_q  [Sets];
    logic [63:0]         data0_q [Sets];
    logic [63:0]         data1_q [Sets];

    logic [31:0]         a;
    logic                offset;
    logic [SET_BITS-1:0] index;
    logic [TAG_BITS-1:0] tag;
    logic                hit0, hit1, hit;
    logic [63:0]         hit_line;
    logic [31:0]         hit_word, fill_word;
    logic                victim;
    logic                unused_addr_bits;

    assign a      = bus.address - BASE_ADDR;
    assign offset = a[2];
    assign index  = a[3 +: SET_BITS];
    assign tag    = a[TagLsb +: TAG_BITS];
    assign unused_addr_bits = ^{a[31:TagLsb+TAG_BITS], a[1:0]};

    assign hit0      = valid0_q[index] && (tag0_q[index] == tag);
    assign hit1      = valid1_q[index] && (tag1_q[index] == tag);
    assign hit       = hit0 || hit1;
    assign hit_line  = hit0 ? data0_q[index] : data1_q[index];
    assign hit_word  = offset ? hit_line[63:32] : hit_line[31:0];
    assign fill_word = offset ? bus.sram_readData[63:32] : bus.sram_readData[31:0];

    // Fill an invalid way first (way0 before way1), otherwise evict the LRU way.
    assign victim = !valid0_q[index] ? 1'b0 :
                    !valid1_q[index] ? 1'b1 : lru_q[index];

    // Handshake back to the MEM stage: hits and SRAM completion are same-cycle.
    always_comb begin
        bus.ready    = 1'b1;
        bus.readData = 32'd0;
        unique case (state_q)
            StIdle: begin
                if (bus.wr_en) begin
                    bus.ready = 1'b0;
                end else if (bus.rd_en) begin
                    bus.ready = hit;
                    if (hit) bus.readData = hit_word;
                end
            end
            StRdMiss: begin
                bus.ready = bus.sram_ready;
                if (bus.sram_ready && bus.rd_en) bus.readData = fill_word;
            end
            StWr: begin
                bus.ready = bus.sram_ready;
            end
            default: bus.ready = 1'b1;
        endcase
    end

    // Controller FSM, SRAM request registers and cache array updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= StIdle;
            valid0_q           <= '0;
            valid1_q           <= '0;
            lru_q              <= '0;
            bus.sram_rd_en     <= 1'b0;
            bus.sram_wr_en     <= 1'b0;
            bus.sram_address   <= 32'd0;
            bus.sram_writeData <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.wr_en) begin
                        state_q            <= StWr;
                        bus.sram_wr_en     <= 1'b1;
                        bus.sram_address   <= bus.address;
                        bus.sram_writeData <= bus.writeData;
                    end else if (bus.rd_en) begin
                        if (hit) begin
                            lru_q[index] <= hit0;
                        end else begin
                            state_q          <= StRdMiss;
                            bus.sram_rd_en   <= 1'b1;
                            bus.sram_address <= {bus.address[31:3], 3'b000};
                        end
                    end
                end
                StRdMiss: begin
                    if (bus.sram_ready) begin
                        state_q        <= StIdle;
                        bus.sram_rd_en <= 1'b0;
                        if (victim) begin
                            valid1_q[index] <= 1'b1;
                            tag1_q[index]   <= tag;
                            data1_q[index]  <= bus.sram_readData;
                            lru_q[index]    <= 1'b0;
                        end else begin
                            valid0_q[index] <= 1'b1;
                            tag0_q[index]   <= tag;
                            data0_q[index]  <= bus.sram_readData;
                            lru_q[index]    <= 1'b1;
                        end
                    end
                end
                StWr: begin
                    if (bus.sram_ready) begin
                        state_q        <= StIdle;
                        bus.sram_wr_en <= 1'b0;
                        // Write-through: only refresh a resident copy, never allocate.
                        if (hit0) begin
                            if (offset) data0_q[index][63:32] <= bus.writeData;
                            else        data0_q[index][31:0]  <= bus.writeData;
                            lru_q[index] <= 1'b1;
                        end else if (hit1) begin
                            if (offset) data1_q[index][63:32] <= bus.writeData;
                            else        data1_q[index][31:0]  <= bus.writeData;
                            lru_q[index] <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_cache_controller.sv
// Randomised bench for sram_cache_controller. The bench plays the SRAM
// controller from a word-addressed memory and predicts hits with a
// recency-ordered list of resident lines (2 per set, LRU eviction).
module tb_sram_cache_controller;

    localparam logic [31:0] Base = 32'd1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_cache_controller_if bus ();

    sram_cache_controller #(
        .BASE_ADDR (Base),
        .SET_BITS  (6),
        .TAG_BITS  (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [int unsigned];  // keyed by byte address >> 2
    int unsigned resident[$];         // line numbers, most recently used at back

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int unsigned w);
        if (mem.exists(w)) return mem[w];
        return w * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic int unsigned line_of(input logic [31:0] addr);
        return (addr - Base) >> 3;
    endfunction

    function automatic int find_line(input int unsigned line);
        foreach (resident[i]) if (resident[i] == line) return i;
        return -1;
    endfunction

    function automatic void touch(input int unsigned line);
        int idx;
        idx = find_line(line);
        if (idx >= 0) resident.delete(idx);
        resident.push_back(line);
    endfunction

    function automatic void fill(input int unsigned line);
        int cnt;
        int first;
        cnt   = 0;
        first = -1;
        foreach (resident[i]) begin
            if (resident[i] % 64 == line % 64) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        if (cnt >= 2) resident.delete(first);
        resident.push_back(line);
    endfunction

    // Random SRAM latency; the cache must keep stalling while we wait.
    task automatic sram_delay();
        int d;
        d = $urandom_range(0, 4);
        repeat (d) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("stall_wait", bus.ready, 1'b0);
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        check_eq("idle_ready", bus.ready, 1'b1);
        check_eq("idle_rdata", bus.readData, 32'd0);
        check_eq("idle_sram_en", {bus.sram_rd_en, bus.sram_wr_en}, 2'b00);
    endtask

    task automatic do_read(input logic [31:0] addr);
        int unsigned line;
        int unsigned w;
        logic [31:0] exp;
        bit          hit;
        line = line_of(addr);
        exp  = mem_rd(addr >> 2);
        hit  = (find_line(line) >= 0);
        w    = {addr[31:3], 3'b000} >> 2;
        @(negedge clk);
        bus.rd_en     = 1'b1;
        bus.wr_en     = 1'b0;
        bus.address   = addr;
        bus.writeData = $urandom;
        #1;
        if (hit) begin
            check_eq("rd_hit_ready", bus.ready, 1'b1);
            check_eq("rd_hit_data", bus.readData, exp);
            @(posedge clk);
            touch(line);
            #1;
            check_eq("rd_hit_no_sram", {bus.sram_rd_en, bus.sram_wr_en}, 2'b00);
        end else begin
            check_eq("rd_miss_stall", bus.ready, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check_eq("rd_miss_req", {bus.sram_rd_en, bus.sram_wr_en}, 2'b10);
            check_eq("rd_miss_addr", bus.sram_address, {addr[31:3], 3'b000});
            sram_delay();
            check_eq("rd_miss_addr_held", bus.sram_address, {addr[31:3], 3'b000});
            bus.sram_readData = {mem_rd(w + 1), mem_rd(w)};
            bus.sram_ready    = 1'b1;
            #1;
            check_eq("rd_fill_ready", bus.ready, 1'b1);
            check_eq("rd_fill_data", bus.readData, exp);
            @(posedge clk);
            fill(line);
            #1;
            bus.sram_ready    = 1'b0;
            bus.sram_readData = {$urandom, $urandom};
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit both);
        int unsigned line;
        bit          hit;
        line = line_of(addr);
        hit  = (find_line(line) >= 0);
        @(negedge clk);
        bus.wr_en     = 1'b1;
        bus.rd_en     = both;
        bus.address   = addr;
        bus.writeData = data;
        #1;
        check_eq("wr_stall", bus.ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_eq("wr_req", {bus.sram_rd_en, bus.sram_wr_en}, 2'b01);
        check_eq("wr_addr", bus.sram_address, addr);
        check_eq("wr_data", bus.sram_writeData, data);
        sram_delay();
        bus.sram_ready = 1'b1;
        #1;
        check_eq("wr_done_ready", bus.ready, 1'b1);
        @(posedge clk);
        mem[addr >> 2] = data;
        if (hit) touch(line);
        #1;
        bus.sram_ready = 1'b0;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
    endtask

    task automatic reset_mid_miss(input logic [31:0] addr);
        @(negedge clk);
        bus.rd_en   = 1'b1;
        bus.wr_en   = 1'b0;
        bus.address = addr;
        #1;
        check_eq("rst_miss_stall", bus.ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_miss_req", bus.sram_rd_en, 1'b1);
        rst       = 1'b1;
        bus.rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resident.delete();
        @(negedge clk);
        check_eq("rst_drop_en", {bus.sram_rd_en, bus.sram_wr_en}, 2'b00);
        check_eq("rst_ready", bus.ready, 1'b1);
    endtask

    function automatic logic [31:0] rand_addr();
        return Base + $urandom_range(0, 3) * 512 + $urandom_range(0, 3) * 8
                    + $urandom_range(0, 1) * 4 + $urandom_range(0, 3);
    endfunction

    initial begin
        rst               = 1'b1;
        bus.rd_en         = 1'b0;
        bus.wr_en         = 1'b0;
        bus.address       = 32'd0;
        bus.writeData     = 32'd0;
        bus.sram_ready    = 1'b0;
        bus.sram_readData = 64'd0;
        mem[Base >> 2]       = 32'h0000_AAAA;
        mem[(Base >> 2) + 1] = 32'h0000_BBBB;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_check();

        do_read(32'd1024);                // cold miss, even word
        do_read(32'd1028);                // hit on the odd word
        do_read(32'd1536);
        do_read(32'd2048);                // evicts tag 0 from set 0
        do_read(32'd1536);
        do_read(32'd1024);                // must miss again
        do_write(32'd1024, 32'h1234, 1'b0);
        do_read(32'd1024);
        do_write(32'd1024 + 5 * 8, 32'h5555, 1'b0);
        do_read(32'd1024 + 5 * 8);        // no-write-allocate: misses
        idle_check();
        reset_mid_miss(32'd1024 + 7 * 8);
        do_read(32'd1024);                // was resident before reset
        idle_check();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) do_read(rand_addr());
            else do_write(rand_addr(), $urandom, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) idle_check();
        end
        idle_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_cache_controller.md
Name: sram_cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.
- Serves read hits with no SRAM access.
- Fills a 64-bit line (two words) on a read miss.
- Forwards every write to SRAM.
- MEM stage stalls the pipeline while ready=0.

Parameters:
BASE_ADDR, 32'd1024, data-memory base address, subtracted before indexing
SET_BITS, 6, log2 of number of sets (64 sets)
TAG_BITS, 10, tag width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
wr_en  input  1  store request from MEM stage
rd_en  input  1  load request from MEM stage
address  input  32  byte address from MEM stage
writeData  input  32  store data
readData  output  32  load data, valid when ready=1 and rd_en=1
ready  output  1  request complete this cycle; 0 stalls pipeline
sram_wr_en  output  1  write request to SRAM controller
sram_rd_en  output  1  read request to SRAM controller
sram_address  output  32  address to SRAM controller; line-aligned on reads (bit 2 cleared)
sram_writeData  output  32  store data to SRAM controller
sram_readData  input  64  line from SRAM controller: [31:0] even word, [63:32] odd word
sram_ready  input  1  SRAM controller done

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Address decode:
  - a = address - BASE_ADDR.
  - offset = a[2] selects the word within the line.
  - index = a[8:3].
  - tag = a[18:9].
  - a[1:0] ignored.
- Storage per set: two ways, each with valid bit, 10-bit tag, two 32-bit data words; one LRU bit per set (0 means way0 is least recently used).
- hitN = validN && tagN == tag; hit = hit0 || hit1.
- Reset: all valid and LRU bits cleared, state=IDLE, sram_wr_en=0, sram_rd_en=0. With no request active, ready=1 and readData=0.
- readData is 0 whenever rd_en=0.
- States: IDLE, RD_MISS, WR.
- IDLE:
  - rd_en && hit: ready=1 combinationally the same cycle; readData = hit way word[offset]; LRU set to the other way at the clock edge; stay IDLE (zero-stall hit).
  - rd_en && !hit: ready=0; go to RD_MISS.
  - wr_en: ready=0; go to WR. wr_en has priority if both enables are high.
  - neither: ready=1.
- RD_MISS:
  - sram_rd_en=1, sram_address = {address[31:3],3'b000}; held stable until sram_ready.
  - On sram_ready: ready=1 the same cycle; readData = sram_readData word[offset].
  - Same edge: victim = invalid way if any (way0 first), else LRU way. Victim gets valid=1, tag, both words; LRU points to the other way; go to IDLE.
- WR:
  - sram_wr_en=1, sram_address=address, sram_writeData=writeData; held until sram_ready.
  - On sram_ready: ready=1; if hit, update the hit way word[offset] with writeData and set LRU to the other way; a miss allocates nothing; go to IDLE.
- Requester holds address, enables and writeData stable while ready=0. The cache does not re-sample them mid-transaction except through combinational hit logic.
- sram_rd_en and sram_wr_en are never both 1; both are 0 in IDLE.
- Reset mid-RD_MISS or mid-WR: next cycle IDLE, SRAM enables deasserted, no array update, all lines invalid. The SRAM controller is reset by the same rst.
- sram_ready while in IDLE is ignored.

Test Plan:
- Reset, then rd_en at 1024 → ready=0; sram_rd_en=1, sram_address=1024. sram_ready after 5 cycles with data {0xBBBB,0xAAAA} → readData=0xAAAA, ready=1 that cycle.
- Read 1028 next → hit: ready=1 same cycle, readData=0xBBBB, no SRAM request.
- Fill index 0 with tags 0, 1, 2 (addresses 1024, 1536, 2048), then re-read 1536 → hit; the 2048 fill evicted tag 0, so re-reading 1024 misses.
- Store 0x1234 to 1024 while cached → sram_wr_en=1, sram_writeData=0x1234; ready only on sram_ready. Following read of 1024 hits with 0x1234.
- Store to an uncached address, then read it → store performs no allocation, read misses.
- Assert rst during RD_MISS before sram_ready → enables drop next cycle; re-reading an address that previously hit now misses.
